// File: rtl/filter_rx_hdr_parser.sv
// Receive-path header parser: extracts L3 destination address and L4 destination port from
// the first beat of each packet and forwards the stream through a 2-entry skid buffer.
module filter_rx_hdr_parser #(
  parameter int DATA_W = 512,
  parameter int USER_W = 48,
  parameter int CNT_W  = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic [DATA_W/8-1:0]   s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic [USER_W-1:0]     s_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic [USER_W-1:0]     m_axis_tuser,
  output logic                  m_meta_sop,
  output logic                  m_meta_is_ipv4,
  output logic                  m_meta_is_ipv6,
  output logic                  m_meta_l4_valid,
  output logic [31:0]           m_meta_ipv4_dst,
  output logic [127:0]          m_meta_ipv6_dst,
  output logic [15:0]           m_meta_dst_port,
  output logic [CNT_W-1:0]      stat_pkt_cnt,
  output logic [CNT_W-1:0]      stat_ipv4_cnt,
  output logic [CNT_W-1:0]      stat_ipv6_cnt,
  output logic [CNT_W-1:0]      stat_runt_cnt
);

  localparam int KEEP_W = DATA_W / 8;

  typedef struct packed {
    logic         sop;
    logic         isIpv4;
    logic         isIpv6;
    logic         l4Valid;
    logic [31:0]  ipv4Dst;
    logic [127:0] ipv6Dst;
    logic [15:0]  dstPort;
  } meta_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic [USER_W-1:0] user;
    meta_t             meta;
  } beat_t;

  typedef enum logic {ST_IDLE, ST_BODY} state_t;

  function automatic logic [7:0] byteAt(input logic [DATA_W-1:0] d, input logic [5:0] idx);
    return d[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic allKept(input logic [KEEP_W-1:0] k, input logic [5:0] lo,
                                   input logic [5:0] hi);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < KEEP_W; i++) begin
      if (6'(i) >= lo && 6'(i) <= hi && !k[i]) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [6:0] keepCount(input logic [KEEP_W-1:0] k);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < KEEP_W; i++) n = n + 7'(k[i]);
    return n;
  endfunction

  logic         vlanTag;
  logic [5:0]   hdrOff;
  logic [15:0]  etype;
  logic         etypeKept;
  logic [7:0]   ipv4Vihl;
  logic [7:0]   ipv4FragHi;
  logic [7:0]   ipv4FragLo;
  logic [7:0]   ipv4Proto;
  logic [7:0]   ipv6NextHdr;
  logic         ipv4CtlKept;
  logic         ipv4L4;
  logic         ipv6L4;
  logic [31:0]  ipv4DstRaw;
  logic [127:0] ipv6DstRaw;
  meta_t        parsedMeta;

  // A single 802.1Q tag shifts every L3/L4 offset by four bytes; anything deeper is not parsed.
  always_comb begin
    vlanTag    = byteAt(s_axis_tdata, 6'd12) == 8'h81 && byteAt(s_axis_tdata, 6'd13) == 8'h00 &&
                 allKept(s_axis_tkeep, 6'd12, 6'd13);
    hdrOff     = vlanTag ? 6'd4 : 6'd0;
    etype      = {byteAt(s_axis_tdata, 6'd12 + hdrOff), byteAt(s_axis_tdata, 6'd13 + hdrOff)};
    etypeKept  = allKept(s_axis_tkeep, 6'd12 + hdrOff, 6'd13 + hdrOff);
    ipv4Vihl   = byteAt(s_axis_tdata, 6'd14 + hdrOff);
    ipv4FragHi = byteAt(s_axis_tdata, 6'd20 + hdrOff);
    ipv4FragLo = byteAt(s_axis_tdata, 6'd21 + hdrOff);
    ipv4Proto  = byteAt(s_axis_tdata, 6'd23 + hdrOff);
    ipv6NextHdr = byteAt(s_axis_tdata, 6'd20 + hdrOff);
    ipv4DstRaw = {byteAt(s_axis_tdata, 6'd30 + hdrOff), byteAt(s_axis_tdata, 6'd31 + hdrOff),
                  byteAt(s_axis_tdata, 6'd32 + hdrOff), byteAt(s_axis_tdata, 6'd33 + hdrOff)};
    ipv6DstRaw = '0;
    for (int i = 0; i < 16; i++) begin
      ipv6DstRaw[8*(15-i) +: 8] = byteAt(s_axis_tdata, 6'd38 + hdrOff + 6'(i));
    end

    parsedMeta        = '0;
    parsedMeta.sop    = 1'b1;
    parsedMeta.isIpv4 = etypeKept && etype == 16'h0800 &&
                        allKept(s_axis_tkeep, 6'd30 + hdrOff, 6'd33 + hdrOff);
    parsedMeta.isIpv6 = etypeKept && etype == 16'h86DD &&
                        allKept(s_axis_tkeep, 6'd38 + hdrOff, 6'd53 + hdrOff);

    ipv4CtlKept = allKept(s_axis_tkeep, 6'd14 + hdrOff, 6'd14 + hdrOff) &&
                  allKept(s_axis_tkeep, 6'd20 + hdrOff, 6'd21 + hdrOff) &&
                  allKept(s_axis_tkeep, 6'd23 + hdrOff, 6'd23 + hdrOff);
    ipv4L4 = parsedMeta.isIpv4 && ipv4CtlKept && ipv4Vihl[3:0] == 4'd5 &&
             !ipv4FragHi[5] && ipv4FragHi[4:0] == 5'd0 && ipv4FragLo == 8'd0 &&
             (ipv4Proto == 8'd6 || ipv4Proto == 8'd17) &&
             allKept(s_axis_tkeep, 6'd36 + hdrOff, 6'd37 + hdrOff);
    ipv6L4 = parsedMeta.isIpv6 && allKept(s_axis_tkeep, 6'd20 + hdrOff, 6'd20 + hdrOff) &&
             (ipv6NextHdr == 8'd6 || ipv6NextHdr == 8'd17) &&
             allKept(s_axis_tkeep, 6'd56 + hdrOff, 6'd57 + hdrOff);
    parsedMeta.l4Valid = ipv4L4 || ipv6L4;

    if (parsedMeta.isIpv4) parsedMeta.ipv4Dst = ipv4DstRaw;
    if (parsedMeta.isIpv6) parsedMeta.ipv6Dst = ipv6DstRaw;
    if (ipv4L4) begin
      parsedMeta.dstPort = {byteAt(s_axis_tdata, 6'd36 + hdrOff), byteAt(s_axis_tdata, 6'd37 + hdrOff)};
    end else if (ipv6L4) begin
      parsedMeta.dstPort = {byteAt(s_axis_tdata, 6'd56 + hdrOff), byteAt(s_axis_tdata, 6'd57 + hdrOff)};
    end
  end

  state_t   state_q;
  meta_t    metaHold_q;
  logic     inReady_q;
  logic     inAccept;
  beat_t    inBeat;

  assign inAccept = s_axis_tvalid && inReady_q;

  always_comb begin
    inBeat      = '0;
    inBeat.data = s_axis_tdata;
    inBeat.keep = s_axis_tkeep;
    inBeat.last = s_axis_tlast;
    inBeat.user = s_axis_tuser;
    inBeat.meta = (state_q == ST_IDLE) ? parsedMeta : metaHold_q;
  end

  // Held metadata is stored with sop cleared so body beats can reuse it unchanged.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      metaHold_q <= '0;
    end else if (inAccept) begin
      case (state_q)
        ST_IDLE: begin
          metaHold_q     <= parsedMeta;
          metaHold_q.sop <= 1'b0;
          state_q        <= s_axis_tlast ? ST_IDLE : ST_BODY;
        end
        ST_BODY: begin
          if (s_axis_tlast) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic [CNT_W-1:0] pktCnt_q, ipv4Cnt_q, ipv6Cnt_q, runtCnt_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pktCnt_q  <= '0;
      ipv4Cnt_q <= '0;
      ipv6Cnt_q <= '0;
      runtCnt_q <= '0;
    end else if (inAccept && state_q == ST_IDLE) begin
      pktCnt_q <= pktCnt_q + CNT_W'(1);
      if (parsedMeta.isIpv4) ipv4Cnt_q <= ipv4Cnt_q + CNT_W'(1);
      if (parsedMeta.isIpv6) ipv6Cnt_q <= ipv6Cnt_q + CNT_W'(1);
      if (s_axis_tlast && keepCount(s_axis_tkeep) < 7'd60) runtCnt_q <= runtCnt_q + CNT_W'(1);
    end
  end

  beat_t outBeat_q, outBeat_d;
  beat_t skidBeat_q, skidBeat_d;
  logic  outValid_q, outValid_d;
  logic  skidValid_q, skidValid_d;
  logic  inReady_d;

  // The skid slot only fills while the output is stalled, and input is refused while it is
  // occupied, so an accepted beat and a skid drain never coincide.
  always_comb begin
    outBeat_d   = outBeat_q;
    outValid_d  = outValid_q;
    skidBeat_d  = skidBeat_q;
    skidValid_d = skidValid_q;
    if (!outValid_q || m_axis_tready) begin
      if (skidValid_q) begin
        outBeat_d   = skidBeat_q;
        outValid_d  = 1'b1;
        skidValid_d = 1'b0;
      end else begin
        outValid_d = inAccept;
        if (inAccept) outBeat_d = inBeat;
      end
    end else if (inAccept) begin
      skidBeat_d  = inBeat;
      skidValid_d = 1'b1;
    end
    inReady_d = !skidValid_d;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      outBeat_q   <= '0;
      outValid_q  <= 1'b0;
      skidBeat_q  <= '0;
      skidValid_q <= 1'b0;
      inReady_q   <= 1'b0;
    end else begin
      outBeat_q   <= outBeat_d;
      outValid_q  <= outValid_d;
      skidBeat_q  <= skidBeat_d;
      skidValid_q <= skidValid_d;
      inReady_q   <= inReady_d;
    end
  end

  assign s_axis_tready   = inReady_q;
  assign m_axis_tvalid   = outValid_q;
  assign m_axis_tdata    = outBeat_q.data;
  assign m_axis_tkeep    = outBeat_q.keep;
  assign m_axis_tlast    = outBeat_q.last;
  assign m_axis_tuser    = outBeat_q.user;
  assign m_meta_sop      = outBeat_q.meta.sop;
  assign m_meta_is_ipv4  = outBeat_q.meta.isIpv4;
  assign m_meta_is_ipv6  = outBeat_q.meta.isIpv6;
  assign m_meta_l4_valid = outBeat_q.meta.l4Valid;
  assign m_meta_ipv4_dst = outBeat_q.meta.ipv4Dst;
  assign m_meta_ipv6_dst = outBeat_q.meta.ipv6Dst;
  assign m_meta_dst_port = outBeat_q.meta.dstPort;
  assign stat_pkt_cnt    = pktCnt_q;
  assign stat_ipv4_cnt   = ipv4Cnt_q;
  assign stat_ipv6_cnt   = ipv6Cnt_q;
  assign stat_runt_cnt   = runtCnt_q;

endmodule

// File: tb/tb_filter_rx_hdr_parser.sv
// Directed bench for filter_rx_hdr_parser: hand-built frames with hand-computed metadata,
// plus a long random-backpressure stream checked against a queue of sent beats.
module tb_filter_rx_hdr_parser;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic          aresetn;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [511:0]  s_axis_tdata;
  logic [63:0]   s_axis_tkeep;
  logic [47:0]   s_axis_tuser;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [511:0]  m_axis_tdata;
  logic [63:0]   m_axis_tkeep;
  logic [47:0]   m_axis_tuser;
  logic          m_meta_sop, m_meta_is_ipv4, m_meta_is_ipv6, m_meta_l4_valid;
  logic [31:0]   m_meta_ipv4_dst;
  logic [127:0]  m_meta_ipv6_dst;
  logic [15:0]   m_meta_dst_port;
  logic [31:0]   stat_pkt_cnt, stat_ipv4_cnt, stat_ipv6_cnt, stat_runt_cnt;

  filter_rx_hdr_parser dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_meta_sop(m_meta_sop), .m_meta_is_ipv4(m_meta_is_ipv4), .m_meta_is_ipv6(m_meta_is_ipv6),
    .m_meta_l4_valid(m_meta_l4_valid), .m_meta_ipv4_dst(m_meta_ipv4_dst),
    .m_meta_ipv6_dst(m_meta_ipv6_dst), .m_meta_dst_port(m_meta_dst_port),
    .stat_pkt_cnt(stat_pkt_cnt), .stat_ipv4_cnt(stat_ipv4_cnt),
    .stat_ipv6_cnt(stat_ipv6_cnt), .stat_runt_cnt(stat_runt_cnt)
  );

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
    logic [47:0]  user;
    logic         sop;
    logic         ipv4;
    logic         ipv6;
    logic         l4v;
    logic [31:0]  v4;
    logic [127:0] v6;
    logic [15:0]  port;
  } obs_t;

  obs_t outQ[$];
  obs_t expQ[$];
  obs_t prevObs;
  logic [511:0] frame;
  int total = 0, passed = 0;
  int accCount = 0, xferCount = 0, readyViol = 0, holdViol = 0;
  bit randReady = 0, trackReady = 0, prevStall = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic obs_t capture();
    obs_t o;
    o.data = m_axis_tdata;  o.keep = m_axis_tkeep;  o.last = m_axis_tlast;  o.user = m_axis_tuser;
    o.sop = m_meta_sop;  o.ipv4 = m_meta_is_ipv4;  o.ipv6 = m_meta_is_ipv6;  o.l4v = m_meta_l4_valid;
    o.v4 = m_meta_ipv4_dst;  o.v6 = m_meta_ipv6_dst;  o.port = m_meta_dst_port;
    return o;
  endfunction

  function automatic logic [511:0] randData();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // One clock: inputs are already driven just after a falling edge, outputs are stable here.
  task automatic step();
    obs_t cur;
    m_axis_tready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    cur = capture();
    if (prevStall && aresetn && cur !== prevObs) holdViol++;
    if (trackReady && (accCount - xferCount) <= 1 && !s_axis_tready) readyViol++;
    if (s_axis_tvalid && s_axis_tready) accCount++;
    if (m_axis_tvalid && m_axis_tready) begin
      outQ.push_back(cur);
      xferCount++;
    end
    prevStall = m_axis_tvalid && !m_axis_tready;
    prevObs = cur;
    @(negedge aclk);
  endtask

  task automatic applyStimulus(input logic [511:0] d, input logic [63:0] k, input logic l,
                               input logic [47:0] u);
    bit acc;
    int n;
    n = 0;
    s_axis_tvalid = 1'b1;  s_axis_tdata = d;  s_axis_tkeep = k;  s_axis_tlast = l;  s_axis_tuser = u;
    do begin
      acc = s_axis_tready;
      step();
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("input accept timeout", 512'(0), 512'(1));
  endtask

  task automatic drain(input int n);
    int k;
    k = 0;
    s_axis_tvalid = 1'b0;
    while (outQ.size() < n && k < 500) begin
      step();
      k++;
    end
    chk("drained beat count", 512'(outQ.size()), 512'(n));
  endtask

  task automatic checkOutput(input string tag, input obs_t o, input logic sop, input logic v4f,
                             input logic v6f, input logic l4, input logic [31:0] v4,
                             input logic [127:0] v6, input logic [15:0] port);
    chk({tag, " sop"}, 512'(o.sop), 512'(sop));
    chk({tag, " is_ipv4"}, 512'(o.ipv4), 512'(v4f));
    chk({tag, " is_ipv6"}, 512'(o.ipv6), 512'(v6f));
    chk({tag, " l4_valid"}, 512'(o.l4v), 512'(l4));
    chk({tag, " ipv4_dst"}, 512'(o.v4), 512'(v4));
    chk({tag, " ipv6_dst"}, 512'(o.v6), 512'(v6));
    chk({tag, " dst_port"}, 512'(o.port), 512'(port));
  endtask

  task automatic checkCounters(input string tag, input int pkt, input int v4, input int v6,
                               input int runt);
    chk({tag, " pkt_cnt"}, 512'(stat_pkt_cnt), 512'(pkt));
    chk({tag, " ipv4_cnt"}, 512'(stat_ipv4_cnt), 512'(v4));
    chk({tag, " ipv6_cnt"}, 512'(stat_ipv6_cnt), 512'(v6));
    chk({tag, " runt_cnt"}, 512'(stat_runt_cnt), 512'(runt));
  endtask

  task automatic setB(input int i, input logic [7:0] v);
    frame[8*i +: 8] = v;
  endtask

  task automatic buildIpv4(input bit vlan, input logic [31:0] dst, input logic [15:0] port,
                           input logic [7:0] proto, input logic [3:0] ihl, input logic [15:0] ff);
    int off;
    off = vlan ? 4 : 0;
    frame = '0;
    if (vlan) begin
      setB(12, 8'h81); setB(13, 8'h00); setB(14, 8'h00); setB(15, 8'h64);
    end
    setB(12 + off, 8'h08); setB(13 + off, 8'h00);
    setB(14 + off, {4'h4, ihl});
    setB(20 + off, ff[15:8]); setB(21 + off, ff[7:0]);
    setB(23 + off, proto);
    for (int i = 0; i < 4; i++) setB(30 + off + i, dst[8*(3-i) +: 8]);
    setB(36 + off, port[15:8]); setB(37 + off, port[7:0]);
  endtask

  task automatic buildIpv6(input bit vlan, input logic [127:0] dst, input logic [7:0] nh,
                           input logic [15:0] port);
    int off;
    off = vlan ? 4 : 0;
    frame = '0;
    if (vlan) begin
      setB(12, 8'h81); setB(13, 8'h00); setB(14, 8'h00); setB(15, 8'h05);
    end
    setB(12 + off, 8'h86); setB(13 + off, 8'hDD);
    setB(14 + off, 8'h60);
    setB(20 + off, nh);
    for (int i = 0; i < 16; i++) setB(38 + off + i, dst[8*(15-i) +: 8]);
    setB(56 + off, port[15:8]); setB(57 + off, port[7:0]);
  endtask

  initial begin
    obs_t o, e;
    logic [511:0] f1, f2, f3, d;
    logic [63:0] k, u64;
    int sent, pkts, len, nMis, expPkt;

    aresetn = 1'b0;  s_axis_tvalid = 1'b0;  s_axis_tdata = '0;  s_axis_tkeep = '0;
    s_axis_tlast = 1'b0;  s_axis_tuser = '0;  m_axis_tready = 1'b1;
    repeat (3) @(negedge aclk);
    chk("reset tready", 512'(s_axis_tready), 512'(0));
    chk("reset tvalid", 512'(m_axis_tvalid), 512'(0));
    chk("reset sop", 512'(m_meta_sop), 512'(0));
    checkCounters("reset", 0, 0, 0, 0);
    aresetn = 1'b1;
    step();
    chk("tready after release", 512'(s_axis_tready), 512'(1));
    repeat (2) step();

    $display("[TB] single-beat IPv4/UDP");
    buildIpv4(0, 32'hC0A80001, 16'h0050, 8'd17, 4'd5, 16'h0000);
    f1 = frame;
    applyStimulus(f1, '1, 1'b1, 48'hABCDEF012345);
    chk("t1 tvalid one cycle after accept", 512'(m_axis_tvalid), 512'(1));
    drain(1);
    o = outQ.pop_front();
    chk("t1 data", o.data, f1);
    chk("t1 user", 512'(o.user), 512'(48'hABCDEF012345));
    checkOutput("t1", o, 1, 1, 0, 1, 32'hC0A80001, 128'h0, 16'h0050);
    checkCounters("t1", 1, 1, 0, 0);

    $display("[TB] VLAN IPv6/TCP three beats");
    buildIpv6(1, 128'h1, 8'd6, 16'd443);
    f1 = frame;  f2 = randData();  f3 = randData();
    applyStimulus(f1, '1, 1'b0, 48'h1);
    applyStimulus(f2, '1, 1'b0, 48'h2);
    applyStimulus(f3, 64'h0000_0000_FFFF_FFFF, 1'b1, 48'h3);
    drain(3);
    o = outQ.pop_front();
    chk("t2 beat1 data", o.data, f1);
    checkOutput("t2 beat1", o, 1, 0, 1, 1, 32'h0, 128'h1, 16'h01BB);
    o = outQ.pop_front();
    chk("t2 beat2 data", o.data, f2);
    checkOutput("t2 beat2", o, 0, 0, 1, 1, 32'h0, 128'h1, 16'h01BB);
    o = outQ.pop_front();
    chk("t2 beat3 data", o.data, f3);
    chk("t2 beat3 keep/last", 512'({o.keep, o.last}), 512'({64'h0000_0000_FFFF_FFFF, 1'b1}));
    checkOutput("t2 beat3", o, 0, 0, 1, 1, 32'h0, 128'h1, 16'h01BB);
    checkCounters("t2", 2, 1, 1, 0);

    $display("[TB] IPv4 IHL=6 and fragmented IPv4");
    buildIpv4(0, 32'h0A000001, 16'h1234, 8'd17, 4'd6, 16'h0000);
    applyStimulus(frame, '1, 1'b1, 48'h0);
    buildIpv4(0, 32'h0A000002, 16'h1234, 8'd6, 4'd5, 16'h2000);
    applyStimulus(frame, '1, 1'b1, 48'h0);
    drain(2);
    o = outQ.pop_front();
    checkOutput("t4 ihl6", o, 1, 1, 0, 0, 32'h0A000001, 128'h0, 16'h0000);
    o = outQ.pop_front();
    checkOutput("t4 frag", o, 1, 1, 0, 0, 32'h0A000002, 128'h0, 16'h0000);
    checkCounters("t4", 4, 3, 1, 0);

    $display("[TB] 40-byte ARP runt");
    frame = randData();
    setB(12, 8'h08); setB(13, 8'h06);
    applyStimulus(frame, 64'h0000_00FF_FFFF_FFFF, 1'b1, 48'h0);
    drain(1);
    o = outQ.pop_front();
    chk("t5 keep", 512'(o.keep), 512'(64'h0000_00FF_FFFF_FFFF));
    checkOutput("t5", o, 1, 0, 0, 0, 32'h0, 128'h0, 16'h0000);
    checkCounters("t5", 5, 3, 1, 1);

    $display("[TB] 1000 beats with random output backpressure");
    randReady = 1;  trackReady = 1;  outQ.delete();  expQ.delete();
    readyViol = 0;  sent = 0;  pkts = 0;
    while (sent < 1000) begin
      len = $urandom_range(1, 4);
      if (len > 1000 - sent) len = 1000 - sent;
      pkts++;
      for (int b = 0; b < len; b++) begin
        d = randData();
        k = '1;
        if (b == 0) d[8*12 +: 8] = 8'h12;
        if (b == len - 1 && b != 0) k = 64'hFFFF_FFFF_FFFF_FFFF >> $urandom_range(0, 63);
        u64 = {$urandom, $urandom};
        e = '0;
        e.data = d;  e.keep = k;  e.last = (b == len - 1);  e.user = u64[47:0];  e.sop = (b == 0);
        expQ.push_back(e);
        applyStimulus(e.data, e.keep, e.last, e.user);
        sent++;
      end
    end
    drain(1000);
    nMis = 0;
    for (int i = 0; i < 1000 && i < outQ.size(); i++) begin
      if (outQ[i] !== expQ[i]) nMis++;
    end
    chk("t3 mismatched beats", 512'(nMis), 512'(0));
    chk("t3 tready low with skid empty", 512'(readyViol), 512'(0));
    chk("t3 outputs changed while stalled", 512'(holdViol), 512'(0));
    randReady = 0;  trackReady = 0;
    expPkt = 5 + pkts;
    checkCounters("t3", expPkt, 3, 1, 1);
    repeat (2) step();

    $display("[TB] reset in the middle of a 4-beat packet");
    buildIpv6(0, 128'h2001_0DB8_0000_0000_0000_0000_0000_0042, 8'd17, 16'd53);
    applyStimulus(frame, '1, 1'b0, 48'h0);
    applyStimulus(randData(), '1, 1'b0, 48'h0);
    s_axis_tvalid = 1'b0;
    aresetn = 1'b0;
    #1;
    chk("t6 reset tvalid", 512'(m_axis_tvalid), 512'(0));
    chk("t6 reset tready", 512'(s_axis_tready), 512'(0));
    chk("t6 reset sop", 512'(m_meta_sop), 512'(0));
    chk("t6 reset ipv6_dst", 512'(m_meta_ipv6_dst), 512'(0));
    checkCounters("t6 reset", 0, 0, 0, 0);
    repeat (2) @(negedge aclk);
    prevStall = 0;
    aresetn = 1'b1;
    outQ.delete();
    step();
    chk("t6 tready after release", 512'(s_axis_tready), 512'(1));
    buildIpv4(1, 32'h0A000005, 16'h1F90, 8'd6, 4'd5, 16'h0000);
    f1 = frame;
    applyStimulus(f1, '1, 1'b1, 48'h0);
    drain(1);
    o = outQ.pop_front();
    chk("t6 data", o.data, f1);
    checkOutput("t6 post-reset", o, 1, 1, 0, 1, 32'h0A000005, 128'h0, 16'h1F90);
    checkCounters("t6", 1, 1, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
